// File: rtl/comparator_pipe.sv
// rtl/comparator_pipe.sv - beat-serial hash vs target comparator with valid/ready result
module comparator_pipe #(
    parameter int HASH_W     = 256,
    parameter int BEAT_W     = 64,
    parameter int TGT_W      = 32,
    parameter int NONCE_W    = 64,
    parameter bit REPORT_ALL = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stop,
    input  logic               le_mode,
    input  logic [TGT_W-1:0]   target,
    input  logic               target_we,
    input  logic [BEAT_W-1:0]  hash_din,
    input  logic               hash_din_valid,
    output logic               hash_re,
    input  logic [NONCE_W-1:0] nonce_din,
    input  logic               nonce_valid,
    output logic               nonce_re,
    output logic               result_valid,
    input  logic               result_ready,
    output logic               result_golden,
    output logic [HASH_W-1:0]  result_hash,
    output logic [NONCE_W-1:0] result_nonce,
    output logic [31:0]        golden_cnt,
    output logic               target_ok
);

    localparam int NBEATS = HASH_W / BEAT_W;
    localparam int NTGT   = HASH_W / TGT_W;
    localparam int BCW    = $clog2(NBEATS);
    localparam int TCW    = $clog2(NTGT + 1);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(NBEATS - 1);
    localparam logic [TCW-1:0] TGT_FULL  = TCW'(NTGT);

    typedef enum logic [1:0] {IDLE, CMP, RES} state_t;

    state_t             state, state_nx;
    logic [HASH_W-1:0]  target_q;
    logic [HASH_W-1:0]  hash_buf;
    logic [TCW-1:0]     tgt_cnt;
    logic [BCW-1:0]     beat;
    logic               lt, eq, le_s;
    logic               last, accept, golden, lt_nx, eq_nx;
    logic [BEAT_W-1:0]  tgt_slice;

    assign last         = (beat == LAST_BEAT);
    assign accept       = hash_re && hash_din_valid;
    assign nonce_re     = accept && last;
    assign result_valid = (state == RES);

    // Running MSB-first compare: once a higher beat differs, lower beats cannot change lt.
    always_comb begin
        tgt_slice = target_q[HASH_W-1 - int'(beat)*BEAT_W -: BEAT_W];
        lt_nx     = lt | (eq & (hash_din < tgt_slice));
        eq_nx     = eq & (hash_din == tgt_slice);
        golden    = lt_nx | (le_s & eq_nx);
    end

    always_comb begin
        state_nx = state;
        hash_re  = 1'b0;
        case (state)
            IDLE: begin
                if (!stop && target_ok && !target_we)
                    state_nx = CMP;
            end
            CMP: begin
                if (stop) begin
                    state_nx = IDLE;
                end else begin
                    hash_re = !last || nonce_valid;
                    if (hash_re && hash_din_valid && last && (REPORT_ALL || golden))
                        state_nx = RES;
                end
            end
            RES: begin
                if (stop)
                    state_nx = IDLE;
                else if (result_ready)
                    state_nx = CMP;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            target_q      <= '0;
            tgt_cnt       <= '0;
            target_ok     <= 1'b0;
            hash_buf      <= '0;
            beat          <= '0;
            lt            <= 1'b0;
            eq            <= 1'b1;
            le_s          <= 1'b0;
            result_golden <= 1'b0;
            result_hash   <= '0;
            result_nonce  <= '0;
            golden_cnt    <= '0;
        end else begin
            state <= state_nx;

            if (state == IDLE && target_we) begin
                target_q <= {target, target_q[HASH_W-1:TGT_W]};
                if (tgt_cnt == TGT_FULL) begin
                    tgt_cnt   <= TCW'(1);
                    target_ok <= (NTGT == 1);
                end else begin
                    tgt_cnt   <= tgt_cnt + 1'b1;
                    target_ok <= (tgt_cnt == TGT_FULL - 1'b1);
                end
            end

            // Any exit from CMP (abort or result) restarts the next hash at beat 0.
            if (stop || state != CMP) begin
                beat <= '0;
                lt   <= 1'b0;
                eq   <= 1'b1;
            end else if (accept) begin
                hash_buf[HASH_W-1 - int'(beat)*BEAT_W -: BEAT_W] <= hash_din;
                if (beat == '0)
                    le_s <= le_mode;
                if (last) begin
                    beat <= '0;
                    lt   <= 1'b0;
                    eq   <= 1'b1;
                    if (golden && golden_cnt != 32'hFFFF_FFFF)
                        golden_cnt <= golden_cnt + 1'b1;
                    if (REPORT_ALL || golden) begin
                        result_golden <= golden;
                        result_hash   <= {hash_buf[HASH_W-1:BEAT_W], hash_din};
                        result_nonce  <= nonce_din;
                    end
                end else begin
                    beat <= beat + 1'b1;
                    lt   <= lt_nx;
                    eq   <= eq_nx;
                end
            end
        end
    end

endmodule

// File: tb/tb_comparator_pipe.sv
// tb/tb_comparator_pipe.sv - scoreboard bench for comparator_pipe, REPORT_ALL=1 and 0 instances
module tb_comparator_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         le_mode, target_we, hash_din_valid, nonce_valid;
    logic [31:0]  target;
    logic [63:0]  hash_din, nonce_din;
    logic         stop_a, stop_b, result_ready_a, result_ready_b;

    logic         hash_re_a, nonce_re_a, rv_a, rg_a, tok_a;
    logic [255:0] rh_a;
    logic [63:0]  rn_a;
    logic [31:0]  gc_a;
    logic         hash_re_b, nonce_re_b, rv_b, rg_b, tok_b;
    logic [255:0] rh_b;
    logic [63:0]  rn_b;
    logic [31:0]  gc_b;

    comparator_pipe #(.REPORT_ALL(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .stop(stop_a), .le_mode(le_mode),
        .target(target), .target_we(target_we),
        .hash_din(hash_din), .hash_din_valid(hash_din_valid), .hash_re(hash_re_a),
        .nonce_din(nonce_din), .nonce_valid(nonce_valid), .nonce_re(nonce_re_a),
        .result_valid(rv_a), .result_ready(result_ready_a), .result_golden(rg_a),
        .result_hash(rh_a), .result_nonce(rn_a), .golden_cnt(gc_a), .target_ok(tok_a)
    );

    comparator_pipe #(.REPORT_ALL(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .stop(stop_b), .le_mode(le_mode),
        .target(target), .target_we(target_we),
        .hash_din(hash_din), .hash_din_valid(hash_din_valid), .hash_re(hash_re_b),
        .nonce_din(nonce_din), .nonce_valid(nonce_valid), .nonce_re(nonce_re_b),
        .result_valid(rv_b), .result_ready(result_ready_b), .result_golden(rg_b),
        .result_hash(rh_b), .result_nonce(rn_b), .golden_cnt(gc_b), .target_ok(tok_b)
    );

    typedef struct {
        logic         g;
        logic [255:0] h;
        logic [63:0]  n;
    } exp_t;

    exp_t         q_a[$];
    exp_t         q_b[$];
    int           n_vec = 0;
    int           n_miss = 0;
    int           cnt_a = 0;
    int           cnt_b = 0;
    int           res_b = 0;
    logic         use_b = 1'b0;
    logic [255:0] tgt_model = '0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic hre();
        return use_b ? hash_re_b : hash_re_a;
    endfunction

    function automatic logic nre();
        return use_b ? nonce_re_b : nonce_re_a;
    endfunction

    // Monitors: ready is chosen at the negedge, so a handshake seen here happens at the next posedge.
    initial begin
        exp_t e;
        result_ready_a = 1'b0;
        forever begin
            @(negedge clk);
            result_ready_a = ($urandom_range(0, 3) != 0);
            if (rst_n && rv_a && result_ready_a) begin
                chk("a_result_expected", q_a.size() != 0, 1);
                if (q_a.size() != 0) begin
                    e = q_a.pop_front();
                    chk("a_golden", rg_a, e.g);
                    chk("a_hash", rh_a, e.h);
                    chk("a_nonce", rn_a, e.n);
                end
            end
        end
    end

    initial begin
        exp_t e;
        result_ready_b = 1'b0;
        forever begin
            @(negedge clk);
            result_ready_b = ($urandom_range(0, 3) != 0);
            if (rst_n && rv_b && result_ready_b) begin
                res_b++;
                chk("b_result_expected", q_b.size() != 0, 1);
                if (q_b.size() != 0) begin
                    e = q_b.pop_front();
                    chk("b_golden", rg_b, e.g);
                    chk("b_hash", rh_b, e.h);
                    chk("b_nonce", rn_b, e.n);
                end
            end
        end
    end

    task automatic drain();
        int t = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("drain", q_a.size() + q_b.size(), 0);
    endtask

    task automatic load_tgt(input logic [255:0] t);
        drain();
        stop_a = 1'b1;
        stop_b = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            target    = t[32*i +: 32];
            target_we = 1'b1;
            @(negedge clk);
            target_we = 1'b0;
            chk("target_ok_a", tok_a, i == 7);
        end
        chk("target_ok_b", tok_b, 1);
        tgt_model = t;
    endtask

    task automatic feed_beat(input logic [63:0] d, input bit last);
        int t = 0;
        hash_din       = d;
        hash_din_valid = 1'b1;
        #1;
        while (!hre() && t < 300) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("beat_accept", hre(), 1);
        if (hre()) begin
            chk("nonce_re_timing", nre(), last);
            @(posedge clk);
        end
        @(negedge clk);
        hash_din_valid = 1'b0;
    endtask

    task automatic send(input logic [255:0] h, input logic [63:0] n, input bit le, input int nstall);
        exp_t e;
        bit   g;
        g   = le ? (h <= tgt_model) : (h < tgt_model);
        e.g = g;
        e.h = h;
        e.n = n;
        if (!use_b) q_a.push_back(e);
        else if (g) q_b.push_back(e);
        if (g) begin
            if (use_b) cnt_b++;
            else cnt_a++;
        end
        le_mode   = le;
        nonce_din = n;
        for (int b = 0; b < 4; b++) begin
            hash_din_valid = 1'b0;
            repeat ($urandom_range(0, 1)) @(negedge clk);
            if (b < 3) begin
                nonce_valid = $urandom_range(0, 1);
            end else begin
                nonce_valid    = 1'b0;
                hash_din       = h[63:0];
                hash_din_valid = 1'b1;
                for (int s = 0; s < nstall; s++) begin
                    #1;
                    chk("stall_hash_re", hre(), 0);
                    @(negedge clk);
                end
                nonce_valid = 1'b1;
            end
            feed_beat(h[255-64*b -: 64], b == 3);
            if (b == 0) le_mode = $urandom_range(0, 1);
        end
        nonce_valid = 1'b0;
        chk("result_latency", use_b ? rv_b : rv_a, use_b ? g : 1'b1);
        chk("golden_cnt", use_b ? gc_b : gc_a, use_b ? cnt_b : cnt_a);
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        logic [255:0] h, t;
        int           k;
        stop_a = 1'b1; stop_b = 1'b1;
        le_mode = 1'b0; target = '0; target_we = 1'b0;
        hash_din = '0; hash_din_valid = 1'b0; nonce_din = '0; nonce_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hash_re", hash_re_a, 0);
        chk("rst_nonce_re", nonce_re_a, 0);
        chk("rst_result_valid", rv_a, 0);
        chk("rst_result_golden", rg_a, 0);
        chk("rst_result_hash", rh_a, 0);
        chk("rst_result_nonce", rn_a, 0);
        chk("rst_golden_cnt", gc_a, 0);
        chk("rst_target_ok", tok_a, 0);
        chk("rst_target_ok_b", tok_b, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) t[32*i +: 32] = 32'(i + 1);
        load_tgt(t);
        stop_a = 1'b0;
        send(tgt_model, 64'd7, 1'b0, 0);
        send(tgt_model, 64'd8, 1'b1, 0);

        load_tgt({32'h0, {224{1'b1}}});
        stop_a = 1'b0;
        send({64'h0, {192{1'b1}}}, 64'd5, 1'b0, 3);
        send({64'h0000_0001_0000_0000, 192'h0}, 64'd9, 1'b1, 0);

        // abort after three beats, then a full hash against the retained target
        h = rand256();
        for (int b = 0; b < 3; b++) feed_beat(h[255-64*b -: 64], 1'b0);
        stop_a = 1'b1;
        #1;
        chk("stop_hash_re", hash_re_a, 0);
        @(negedge clk);
        chk("stop_result_valid", rv_a, 0);
        stop_a = 1'b0;
        send(tgt_model - 1, 64'd11, 1'b0, 1);

        for (int i = 0; i < 40; i++) begin
            if (i % 10 == 0) begin
                load_tgt(rand256());
                stop_a = 1'b0;
            end
            h = tgt_model;
            case ($urandom_range(0, 4))
                0: h = tgt_model;
                1: h = tgt_model - 1;
                2: h = tgt_model + 1;
                3: begin
                    k = $urandom_range(0, 3);
                    h[64*k +: 64] = {$urandom, $urandom};
                end
                default: h = rand256();
            endcase
            send(h, {$urandom, $urandom}, $urandom_range(0, 1), $urandom_range(0, 2));
        end

        load_tgt({4{64'h0123_4567_89AB_CDEF}});
        use_b  = 1'b1;
        stop_b = 1'b0;
        send(tgt_model, 64'd21, 1'b0, 0);
        send(tgt_model + 5, 64'd22, 1'b1, 0);
        send(tgt_model - 1, 64'd23, 1'b0, 0);
        send({64'hFFFF_FFFF_FFFF_FFFF, 192'h0}, 64'd24, 1'b1, 0);
        drain();
        chk("b_result_count", res_b, 1);
        for (int i = 0; i < 8; i++) begin
            h = (i % 2 == 0) ? tgt_model - 64'($urandom_range(0, 2)) : rand256();
            send(h, {$urandom, $urandom}, $urandom_range(0, 1), $urandom_range(0, 2));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
